// File: rtl/sa_tile_feeder_if.sv
// Bundle of tile control, array handshake and banked-SRAM signals for sa_tile_feeder.
// Ports: tile setup (start, m0, c0, m_lim, c_lim, k_len, x_base, w_base, w_stride),
//        array side (start_mul, stall_mul, sc_valid_queue, sc_x_data, sc_w_data),
//        SRAM side (x/w_mem_re, x/w_mem_addr, x/w_mem_rdata), status (busy, tile_done, err).
interface sa_tile_feeder_if #(
  parameter int N  = 64,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic              start;
  logic [15:0]       m0;
  logic [15:0]       c0;
  logic [15:0]       m_lim;
  logic [15:0]       c_lim;
  logic [15:0]       k_len;
  logic [AW-1:0]     x_base;
  logic [AW-1:0]     w_base;
  logic [15:0]       w_stride;
  logic              start_mul;
  logic              stall_mul;
  logic [N-1:0]      sc_valid_queue;
  logic [N*DW-1:0]   sc_x_data;
  logic [N*DW-1:0]   sc_w_data;
  logic [N-1:0]      x_mem_re;
  logic [N*AW-1:0]   x_mem_addr;
  logic [N*DW-1:0]   x_mem_rdata;
  logic [N-1:0]      w_mem_re;
  logic [N*AW-1:0]   w_mem_addr;
  logic [N*DW-1:0]   w_mem_rdata;
  logic              busy;
  logic              tile_done;
  logic              err;

  // master: the feeder itself
  modport master (
    input  start, m0, c0, m_lim, c_lim, k_len, x_base, w_base, w_stride,
    input  stall_mul, sc_valid_queue, x_mem_rdata, w_mem_rdata,
    output start_mul, sc_x_data, sc_w_data, x_mem_re, x_mem_addr,
    output w_mem_re, w_mem_addr, busy, tile_done, err
  );

  // slave: the controller / array / SRAM environment around the feeder
  modport slave (
    output start, m0, c0, m_lim, c_lim, k_len, x_base, w_base, w_stride,
    output stall_mul, sc_valid_queue, x_mem_rdata, w_mem_rdata,
    input  start_mul, sc_x_data, sc_w_data, x_mem_re, x_mem_addr,
    input  w_mem_re, w_mem_addr, busy, tile_done, err
  );
endinterface

// File: rtl/sa_tile_feeder.sv
// Per-tile operand streamer for systolic_array_top: arms N lane pointers, launches, serves lane requests.
// Latency: N ARM cycles + 1 LAUNCH before start_mul; operands return 1 cycle after a request.
// Backpressure: none; the array paces itself via stall_mul, out-of-range requests return zero.
// Ports: clk, rst (async active-high), bus (sa_tile_feeder_if.master).
// Optional: define FEEDER_WATCHDOG_EN to abort a STREAM that lasts 200000 cycles.
module sa_tile_feeder #(
  parameter int N         = 64,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int DRAIN_CYC = 2*N
) (
  input  logic             clk,
  input  logic             rst,
  sa_tile_feeder_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_LAUNCH, S_WAIT_BUSY, S_STREAM, S_DRAIN
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   cnt;
  logic          start_acc, wait_to, drain_end, wd_to;
  logic          err_q, tile_done_q;

  logic [15:0]   m0_q, c0_q, m_lim_q, c_lim_q, k_len_q, w_stride_q;
  logic [AW-1:0] x_acc, w_acc;
  logic [AW-1:0] xa [N];
  logic [AW-1:0] wa [N];
  logic [15:0]   kx [N];
  logic [15:0]   kw [N];
  logic [N-1:0]  serve, x_re, w_re, x_rd_q, w_rd_q;

  // Requests are only honoured while the array is actually busy in STREAM; the
  // cycle in which stall_mul drops issues nothing, so DRAIN sees no late data.
  assign serve = (state == S_STREAM && bus.stall_mul) ? bus.sc_valid_queue : '0;

`ifdef FEEDER_WATCHDOG_EN
  localparam logic [19:0] WD_LIMIT = 20'd200000;
  logic [19:0] wd_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    wd_cnt <= '0;
    else if (state == S_STREAM) wd_cnt <= wd_cnt + 20'd1;
    else                        wd_cnt <= '0;
  end
  assign wd_to = (state == S_STREAM) && bus.stall_mul && (wd_cnt == WD_LIMIT - 20'd1);
`else
  assign wd_to = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    wait_to   = 1'b0;
    drain_end = 1'b0;
    case (state)
      S_IDLE:      if (bus.start) begin
                     state_nxt = S_ARM;
                     start_acc = 1'b1;
                   end
      S_ARM:       if (cnt == 16'(N-1)) state_nxt = S_LAUNCH;
      S_LAUNCH:    state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: if (bus.stall_mul) state_nxt = S_STREAM;
                   else if (cnt == 16'd15) begin
                     state_nxt = S_IDLE;
                     wait_to   = 1'b1;
                   end
      S_STREAM:    if (!bus.stall_mul) state_nxt = S_DRAIN;
                   else if (wd_to)     state_nxt = S_IDLE;
      S_DRAIN:     if (cnt == 16'(DRAIN_CYC-1)) begin
                     state_nxt = S_IDLE;
                     drain_end = 1'b1;
                   end
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Shared phase counter: restarts on every state change, so it is the cycle
  // index within ARM (lane being loaded), WAIT_BUSY and DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       cnt <= '0;
    else if (state_nxt != state || state == S_IDLE) cnt <= '0;
    else                                           cnt <= cnt + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q       <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      tile_done_q <= drain_end;
      if (start_acc)
        err_q <= 1'b0;
      else if (wait_to || wd_to || (|bus.sc_valid_queue && state != S_STREAM))
        err_q <= 1'b1;
    end
  end

  // Lane base addresses: one shared multiply for the tile row offset, then a
  // running add of k_len (X) / 1 (W) hands each lane its start in ARM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_q <= '0; c0_q <= '0; m_lim_q <= '0; c_lim_q <= '0;
      k_len_q <= '0; w_stride_q <= '0;
      x_acc <= '0; w_acc <= '0;
      x_rd_q <= '0; w_rd_q <= '0;
      for (int i = 0; i < N; i++) begin
        xa[i] <= '0; wa[i] <= '0; kx[i] <= '0; kw[i] <= '0;
      end
    end else begin
      if (start_acc) begin
        m0_q       <= bus.m0;
        c0_q       <= bus.c0;
        m_lim_q    <= bus.m_lim;
        c_lim_q    <= bus.c_lim;
        k_len_q    <= bus.k_len;
        w_stride_q <= bus.w_stride;
        x_acc      <= bus.x_base + AW'(32'(bus.m0) * 32'(bus.k_len));
        w_acc      <= bus.w_base + AW'(bus.c0);
      end else if (state == S_ARM) begin
        x_acc <= x_acc + AW'(k_len_q);
        w_acc <= w_acc + AW'(1);
      end
      for (int i = 0; i < N; i++) begin
        if (state == S_ARM && cnt == 16'(i)) begin
          xa[i] <= x_acc;
          wa[i] <= w_acc;
          kx[i] <= '0;
          kw[i] <= '0;
        end else begin
          if (x_re[i]) begin
            xa[i] <= xa[i] + AW'(1);
            kx[i] <= kx[i] + 16'd1;
          end
          if (w_re[i]) begin
            wa[i] <= wa[i] + AW'(w_stride_q);
            kw[i] <= kw[i] + 16'd1;
          end
        end
      end
      x_rd_q <= x_re;
      w_rd_q <= w_re;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic x_rv, w_rv;
    // 17-bit compares so m0+i / c0+i cannot wrap back into range; kx/kw stop
    // at k_len because the read (and hence the increment) needs kx < k_len.
    assign x_rv = (({1'b0, m0_q} + 17'(i)) < {1'b0, m_lim_q}) && (kx[i] < k_len_q);
    assign w_rv = (({1'b0, c0_q} + 17'(i)) < {1'b0, c_lim_q}) && (kw[i] < k_len_q);
    assign x_re[i] = serve[i] && x_rv;
    assign w_re[i] = serve[i] && w_rv;
    assign bus.x_mem_addr[i*AW +: AW] = x_re[i] ? xa[i] : '0;
    assign bus.w_mem_addr[i*AW +: AW] = w_re[i] ? wa[i] : '0;
    assign bus.sc_x_data[i*DW +: DW]  = x_rd_q[i] ? bus.x_mem_rdata[i*DW +: DW] : '0;
    assign bus.sc_w_data[i*DW +: DW]  = w_rd_q[i] ? bus.w_mem_rdata[i*DW +: DW] : '0;
  end

  assign bus.x_mem_re  = x_re;
  assign bus.w_mem_re  = w_re;
  assign bus.start_mul = (state == S_LAUNCH);
  assign bus.busy      = (state != S_IDLE);
  assign bus.tile_done = tile_done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_sa_tile_feeder.sv
// Bench for sa_tile_feeder with N=4, DRAIN_CYC=8 and a 1-cycle SRAM model.
module tb_sa_tile_feeder;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sa_tile_feeder_if #(.N(N), .AW(AW), .DW(DW)) bus ();
  sa_tile_feeder #(.N(N), .AW(AW), .DW(DW), .DRAIN_CYC(DC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] xfn(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction
  function automatic logic [31:0] wfn(input logic [31:0] a);
    return 32'h5A00_0000 ^ a;
  endfunction

  // SRAM model: data one cycle after re, garbage when no read was issued
  logic [N*DW-1:0] xr = '0, wr = '0;
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      xr[i*DW +: DW] <= bus.x_mem_re[i] ? xfn(bus.x_mem_addr[i*AW +: AW]) : 32'hDEADBEEF;
      wr[i*DW +: DW] <= bus.w_mem_re[i] ? wfn(bus.w_mem_addr[i*AW +: AW]) : 32'hDEADBEEF;
    end
  end
  assign bus.x_mem_rdata = xr;
  assign bus.w_mem_rdata = wr;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0][31:0] x;
    logic [N-1:0][31:0] w;
  } exp_t;
  exp_t sb[$];

  logic [31:0] tm0, tc0, tml, tcl, tk, txb, twb, tws;
  int kxm[N];
  int kwm[N];

  task automatic launch(input logic [15:0] m0, input logic [15:0] c0, input logic [15:0] ml,
                        input logic [15:0] cl, input logic [15:0] k, input logic [31:0] xb,
                        input logic [31:0] wb, input logic [15:0] ws);
    int n;
    bit found;
    @(posedge clk); #1;
    bus.m0 = m0; bus.c0 = c0; bus.m_lim = ml; bus.c_lim = cl; bus.k_len = k;
    bus.x_base = xb; bus.w_base = wb; bus.w_stride = ws; bus.start = 1'b1;
    tm0 = 32'(m0); tc0 = 32'(c0); tml = 32'(ml); tcl = 32'(cl); tk = 32'(k);
    txb = xb; twb = wb; tws = 32'(ws);
    for (int i = 0; i < N; i++) begin kxm[i] = 0; kwm[i] = 0; end
    @(negedge clk);
    n = 1;
    found = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 2; c <= 20 && !found; c++) begin
      @(negedge clk);
      if (c == 2) begin
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("err_clear_on_start", 32'(bus.err), 32'd0);
      end
      if (bus.start_mul) begin found = 1'b1; n = c; end
    end
    check("start_mul_cycle", n, 6);
  endtask

  task automatic stall_up();
    @(posedge clk); #1;
    bus.stall_mul = 1'b1;
    @(negedge clk);
    check("start_mul_single", 32'(bus.start_mul), 32'd0);
  endtask

  task automatic stream_cycle(input logic [N-1:0] req);
    exp_t e;
    logic xv, wv;
    logic [31:0] xa_e, wa_e;
    @(posedge clk); #1;
    bus.sc_valid_queue = req;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int i = 0; i < N; i++) begin
        check($sformatf("sc_x_data[%0d]", i), bus.sc_x_data[i*DW +: DW], e.x[i]);
        check($sformatf("sc_w_data[%0d]", i), bus.sc_w_data[i*DW +: DW], e.w[i]);
      end
    end
    for (int i = 0; i < N; i++) begin
      xv   = req[i] && (tm0 + 32'(i) < tml) && (32'(kxm[i]) < tk);
      wv   = req[i] && (tc0 + 32'(i) < tcl) && (32'(kwm[i]) < tk);
      xa_e = txb + (tm0 + 32'(i)) * tk + 32'(kxm[i]);
      wa_e = twb + tc0 + 32'(i) + 32'(kwm[i]) * tws;
      check($sformatf("x_mem_re[%0d]", i), 32'(bus.x_mem_re[i]), 32'(xv));
      check($sformatf("w_mem_re[%0d]", i), 32'(bus.w_mem_re[i]), 32'(wv));
      if (xv) begin
        check($sformatf("x_mem_addr[%0d]", i), bus.x_mem_addr[i*AW +: AW], xa_e);
        kxm[i]++;
      end
      if (wv) begin
        check($sformatf("w_mem_addr[%0d]", i), bus.w_mem_addr[i*AW +: AW], wa_e);
        kwm[i]++;
      end
      e.x[i] = xv ? xfn(xa_e) : 32'h0;
      e.w[i] = wv ? wfn(wa_e) : 32'h0;
    end
    sb.push_back(e);
  endtask

  task automatic sb_drain();
    exp_t e;
    @(posedge clk); #1;
    bus.sc_valid_queue = '0;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      for (int i = 0; i < N; i++) begin
        check($sformatf("sc_x_tail[%0d]", i), bus.sc_x_data[i*DW +: DW], e.x[i]);
        check($sformatf("sc_w_tail[%0d]", i), bus.sc_w_data[i*DW +: DW], e.w[i]);
      end
    end
  endtask

  task automatic end_tile();
    int first, pulses;
    first = 0;
    pulses = 0;
    @(posedge clk); #1;
    bus.stall_mul = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 3) check("drain_data_zero", 32'(|{bus.sc_x_data, bus.sc_w_data}), 32'd0);
      if (bus.tile_done) begin
        pulses++;
        if (first == 0) begin
          first = c;
          check("busy_at_done", 32'(bus.busy), 32'd0);
        end
      end
    end
    check("tile_done_cycle", first, 10);
    check("tile_done_pulses", pulses, 1);
  endtask

  task automatic run_tile(input logic [15:0] m0, input logic [15:0] ml, input int ncyc,
                          input logic [31:0] masks);
    launch(m0, 16'd0, ml, 16'd4, 16'd3, 32'h100, 32'h200, 16'd4);
    stall_up();
    for (int c = 0; c < ncyc; c++) stream_cycle(masks[c*4 +: 4]);
    sb_drain();
    end_tile();
  endtask

  initial begin
    int first_err, dones;
    bus.start = 1'b0; bus.m0 = '0; bus.c0 = '0; bus.m_lim = '0; bus.c_lim = '0;
    bus.k_len = '0; bus.x_base = '0; bus.w_base = '0; bus.w_stride = '0;
    bus.stall_mul = 1'b0; bus.sc_valid_queue = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_start_mul", 32'(bus.start_mul), 32'd0);
    check("rst_tile_done", 32'(bus.tile_done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_re", 32'({bus.x_mem_re, bus.w_mem_re}), 32'd0);
    check("rst_data", 32'(|{bus.sc_x_data, bus.sc_w_data}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Tile A: full tile, 4th request runs past k_len
    run_tile(16'd0, 16'd4, 4, 32'h0000_FFFF);
    // Tile B: rows 6,7 beyond m_lim, mixed request masks
    run_tile(16'd4, 16'd6, 5, 32'h000F_A5FF);

    // Array never reports busy: timeout error, no tile_done
    launch(16'd0, 16'd0, 16'd4, 16'd4, 16'd3, 32'h100, 32'h200, 16'd4);
    first_err = 0;
    dones = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (bus.err && first_err == 0) first_err = c;
      if (bus.tile_done) dones++;
    end
    check("timeout_err_cycle", first_err, 17);
    check("timeout_no_done", dones, 0);
    check("timeout_idle", 32'(bus.busy), 32'd0);

    // Request while idle: ignored, zero operand, err stays set
    @(posedge clk); #1;
    bus.sc_valid_queue = 4'b0001;
    @(negedge clk);
    check("idle_req_no_re", 32'(bus.x_mem_re), 32'd0);
    @(posedge clk); #1;
    bus.sc_valid_queue = '0;
    @(negedge clk);
    check("idle_req_data_zero", bus.sc_x_data[31:0], 32'd0);
    check("idle_req_err", 32'(bus.err), 32'd1);

    // Reset in the middle of STREAM
    launch(16'd0, 16'd0, 16'd4, 16'd4, 16'd3, 32'h100, 32'h200, 16'd4);
    stall_up();
    stream_cycle(4'b1111);
    stream_cycle(4'b1111);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_re", 32'({bus.x_mem_re, bus.w_mem_re}), 32'd0);
    check("midrst_data", 32'(|{bus.sc_x_data, bus.sc_w_data}), 32'd0);
    check("midrst_start_mul", 32'(bus.start_mul), 32'd0);
    check("midrst_tile_done", 32'(bus.tile_done), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    bus.sc_valid_queue = '0;
    bus.stall_mul = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    run_tile(16'd0, 16'd4, 4, 32'h0000_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
